// File: rtl/dte20_port.sv
// dte20_port -- DTE20 front-end interface port.
//
// KL10 EBUS slave for one device select (DEV_CS). Answers CONO/CONI/DATAO/
// DATAI from the EBOX, raises a one-hot PI request, and exposes a small
// register file to the console front end. Bit numbering is DEC (bit 0 = MSB).
//
// Ports:
//   clk30        system clock, all state changes on the rising edge
//   CROBAR       synchronous active-high reset
//   ebusCS       EBUS controller select, compared against DEV_CS
//   ebusFunc     0=CONO 1=CONI 2=DATAO 3=DATAI, 4-7 ignored
//   ebusDemand   EBOX demand, held for the whole transfer
//   ebusDataIn   EBUS write data
//   ebusXfer     transfer acknowledge (high while in XFER)
//   ebusDriving  port is driving read data onto the EBUS
//   ebusDataOut  EBUS read data, 0 when not driving
//   ebusPI       one-hot PI request on channel PICH
//   feWrite      front-end write strobe
//   feAddr       front-end register address
//   feDataIn     front-end write data
//   feDataOut    front-end read data (combinational from feAddr)
//   feIntReq     interrupt to the front end (TO11DB)
module dte20_port #(
   parameter logic [0:6] DEV_CS = 7'o100
) (
   input  logic        clk30,
   input  logic        CROBAR,
   input  logic [0:6]  ebusCS,
   input  logic [0:2]  ebusFunc,
   input  logic        ebusDemand,
   input  logic [0:35] ebusDataIn,
   output logic        ebusXfer,
   output logic        ebusDriving,
   output logic [0:35] ebusDataOut,
   output logic [1:7]  ebusPI,
   input  logic        feWrite,
   input  logic [1:0]  feAddr,
   input  logic [0:35] feDataIn,
   output logic [0:35] feDataOut,
   output logic        feIntReq
);

   typedef enum logic {IDLE, XFER} state_t;
   typedef enum logic [1:0] {FN_CONO, FN_CONI, FN_DATAO, FN_DATAI} func_t;

   state_t      state, state_next;
   func_t       func_q;
   func_t       fn_req;
   logic        start;

   logic        to11db, to10db, pien;
   logic [2:0]  pich;
   logic [0:35] tofe, fromfe;
   logic [0:35] coni_word;

   logic        cono, datao;
   logic        kl_set11, kl_clr10, fe_set10, fe_clr11, fe_wr0, fe_wr2;
   logic        pi_active;

   // Functions 4-7 have ebusFunc[0]=1 and never start a transfer, so only
   // the low two bits need latching.
   assign fn_req = func_t'(ebusFunc[1:2]);

   always_ff @(posedge clk30) begin
      if (CROBAR) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next  = state;
      start       = 1'b0;
      ebusXfer    = 1'b0;
      ebusDriving = 1'b0;
      case (state)
         IDLE: begin
            if (ebusDemand && (ebusCS == DEV_CS) && !ebusFunc[0]) begin
               start      = 1'b1;
               state_next = XFER;
            end
         end
         XFER: begin
            ebusXfer    = 1'b1;
            ebusDriving = (func_q == FN_CONI) || (func_q == FN_DATAI);
            if (!ebusDemand) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Side effects fire only on the IDLE->XFER edge, so held demand acts once.
   assign cono     = start && (fn_req == FN_CONO);
   assign datao    = start && (fn_req == FN_DATAO);
   assign kl_set11 = cono && ebusDataIn[22];
   assign kl_clr10 = cono && ebusDataIn[23];
   assign fe_wr0   = feWrite && (feAddr == 2'd0);
   assign fe_wr2   = feWrite && (feAddr == 2'd2);
   assign fe_set10 = fe_wr0 && feDataIn[35];
   assign fe_clr11 = fe_wr0 && feDataIn[34];

   always_ff @(posedge clk30) begin
      if (CROBAR) begin
         func_q <= FN_CONO;
         to11db <= 1'b0;
         to10db <= 1'b0;
         pien   <= 1'b0;
         pich   <= '0;
         tofe   <= '0;
         fromfe <= '0;
      end else begin
         if (start) func_q <= fn_req;
         // Set wins over a same-cycle clear from the other side.
         to11db <= kl_set11 | (to11db & ~fe_clr11);
         to10db <= fe_set10 | (to10db & ~kl_clr10);
         if (cono && ebusDataIn[31]) begin
            pien <= ebusDataIn[32];
            pich <= ebusDataIn[33:35];
         end
         if (datao)  tofe   <= ebusDataIn;
         if (fe_wr2) fromfe <= feDataIn;
      end
   end

   always_comb begin
      coni_word        = '0;
      coni_word[22]    = to11db;
      coni_word[23]    = to10db;
      coni_word[32]    = pien;
      coni_word[33:35] = pich;
   end

   always_comb begin
      ebusDataOut = '0;
      if (ebusDriving) ebusDataOut = (func_q == FN_CONI) ? coni_word : fromfe;
   end

   assign pi_active = to10db && pien && (pich != 3'd0);

   always_comb begin
      ebusPI = '0;
      for (int unsigned i = 1; i <= 7; i++) begin
         ebusPI[i] = pi_active && (pich == 3'(i));
      end
   end

   always_comb begin
      feDataOut = '0;
      case (feAddr)
         2'd0: begin
            feDataOut[34] = to11db;
            feDataOut[35] = to10db;
         end
         2'd1:    feDataOut = tofe;
         2'd2:    feDataOut = fromfe;
         default: feDataOut = coni_word;
      endcase
   end

   assign feIntReq = to11db;

endmodule

// File: tb/tb_dte20_port.sv
// tb_dte20_port -- self-checking bench for dte20_port.
// Directed scenarios followed by randomized traffic; every cycle all outputs
// are compared against a behavioural model of the port kept in this file.
module tb_dte20_port;

   localparam logic [6:0] DEV = 7'o100;

   logic        clk30 = 1'b0;
   logic        crobar;
   logic [6:0]  cs;
   logic [2:0]  fn;
   logic        demand;
   logic [35:0] din;
   logic        xfer, driving;
   logic [35:0] dout;
   logic [6:0]  pi;
   logic        fe_wr;
   logic [1:0]  fe_addr;
   logic [35:0] fe_din, fe_dout;
   logic        fe_int;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk30 = ~clk30;

   dte20_port #(.DEV_CS(7'o100)) dut (
      .clk30(clk30), .CROBAR(crobar),
      .ebusCS(cs), .ebusFunc(fn), .ebusDemand(demand), .ebusDataIn(din),
      .ebusXfer(xfer), .ebusDriving(driving), .ebusDataOut(dout), .ebusPI(pi),
      .feWrite(fe_wr), .feAddr(fe_addr), .feDataIn(fe_din),
      .feDataOut(fe_dout), .feIntReq(fe_int)
   );

   // Reference model state (bench vectors are [35:0]; DEC bit k is bit 35-k)
   bit          m11, m10, mpien, mbusy;
   logic [2:0]  mpich;
   logic [35:0] mtofe, mfromfe;
   int          mfunc;

   function automatic bit db(input logic [35:0] v, input int k);
      return v[35-k];
   endfunction

   task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %o expected %o at %0t", tag, got, exp, $time);
   endtask

   task automatic model_edge();
      bit start, kcono;
      if (crobar) begin
         m11 = 0; m10 = 0; mpien = 0; mpich = 0;
         mtofe = 0; mfromfe = 0; mbusy = 0; mfunc = 0;
         return;
      end
      start = !mbusy && demand && cs == DEV && fn <= 3;
      kcono = start && fn == 0;
      begin
         bit n11, n10;
         n11 = (kcono && db(din, 22)) ? 1'b1
             : (fe_wr && fe_addr == 0 && db(fe_din, 34)) ? 1'b0 : m11;
         n10 = (fe_wr && fe_addr == 0 && db(fe_din, 35)) ? 1'b1
             : (kcono && db(din, 23)) ? 1'b0 : m10;
         m11 = n11; m10 = n10;
      end
      if (kcono && db(din, 31)) begin
         mpien = db(din, 32);
         mpich = din[2:0];
      end
      if (start && fn == 2) mtofe = din;
      if (fe_wr && fe_addr == 2) mfromfe = fe_din;
      if (!mbusy) begin
         mbusy = start;
         if (start) mfunc = fn;
      end else if (!demand) mbusy = 0;
   endtask

   function automatic logic [35:0] m_coni();
      return (36'(m11) << 13) | (36'(m10) << 12) | (36'(mpien) << 3) | 36'(mpich);
   endfunction

   task automatic compare_all();
      logic [35:0] e_dout, e_fe;
      logic [6:0]  e_pi;
      bit          e_drv;
      e_drv  = mbusy && (mfunc == 1 || mfunc == 3);
      e_dout = !e_drv ? 36'd0 : (mfunc == 1 ? m_coni() : mfromfe);
      e_pi   = (m10 && mpien && mpich != 0) ? (7'd1 << (7 - mpich)) : 7'd0;
      case (fe_addr)
         2'd0:    e_fe = (36'(m11) << 1) | 36'(m10);
         2'd1:    e_fe = mtofe;
         2'd2:    e_fe = mfromfe;
         default: e_fe = m_coni();
      endcase
      check("xfer",    36'(xfer),    36'(mbusy));
      check("driving", 36'(driving), 36'(e_drv));
      check("dout",    dout,         e_dout);
      check("pi",      36'(pi),      36'(e_pi));
      check("feint",   36'(fe_int),  36'(m11));
      check("fedout",  fe_dout,      e_fe);
   endtask

   // One clock: drive inputs, take the edge in DUT and model, then compare.
   task automatic cyc(input bit r, input bit dem, input logic [6:0] c, input logic [2:0] f,
                      input logic [35:0] d, input bit w, input logic [1:0] a, input logic [35:0] fd);
      crobar = r; demand = dem; cs = c; fn = f; din = d;
      fe_wr = w; fe_addr = a; fe_din = fd;
      @(posedge clk30);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic idle(input logic [1:0] a);
      cyc(0, 0, DEV, 0, 0, 0, a, 0);
   endtask

   task automatic cono(input logic [35:0] d);
      cyc(0, 1, DEV, 0, d, 0, 0, 0);
      idle(0);
   endtask

   initial begin
      // Reset: two cycles, then read every FE address while still in reset
      cyc(1, 0, DEV, 0, 0, 0, 0, 0);
      cyc(1, 0, DEV, 0, 0, 0, 0, 0);
      for (int a = 0; a < 4; a++) begin
         cyc(1, 0, DEV, 0, 0, 0, 2'(a), 0);
         check("rst_fedout", fe_dout, 36'd0);
      end
      check("rst_xfer", 36'(xfer), 36'd0);
      check("rst_pi", 36'(pi), 36'd0);

      // DATAO, then FE read of TOFE
      idle(0);
      cyc(0, 1, DEV, 2, 36'o123456701234, 0, 1, 0);
      check("datao_ack", 36'(xfer), 36'd1);
      cyc(0, 1, DEV, 2, 36'o123456701234, 0, 1, 0);
      check("datao_hold", 36'(xfer), 36'd1);
      idle(1);
      check("datao_drop", 36'(xfer), 36'd0);
      check("tofe", fe_dout, 36'o123456701234);
      // Wrong CS: no acknowledge, no change
      cyc(0, 1, DEV ^ 7'd1, 2, 36'o111111111111, 0, 1, 0);
      check("badcs_ack", 36'(xfer), 36'd0);
      idle(1);
      check("badcs_tofe", fe_dout, 36'o123456701234);

      // FE write FROMFE, then DATAI
      cyc(0, 0, DEV, 0, 0, 1, 2, 36'o777000000777);
      cyc(0, 1, DEV, 3, 0, 0, 2, 0);
      check("datai_drv", 36'(driving), 36'd1);
      check("datai_data", dout, 36'o777000000777);
      cyc(0, 1, DEV, 3, 0, 0, 2, 0);
      idle(2);
      check("datai_end", dout, 36'd0);

      // PIEN=1, PICH=5 (bits 31,32,33,35), FE rings KL doorbell
      cono(36'o000000000035);
      cyc(0, 0, DEV, 0, 0, 1, 0, 36'd1);
      check("pi_ch5", 36'(pi), 36'(7'b0000100));
      cono(36'd1 << 12);
      check("pi_clr", 36'(pi), 36'd0);
      cono(36'o000000000030);             // PIEN=1, PICH=0
      cyc(0, 0, DEV, 0, 0, 1, 0, 36'd1);
      check("pi_ch0", 36'(pi), 36'd0);

      // Doorbell to FE
      cono(36'd1 << 13);
      check("feint_set", 36'(fe_int), 36'd1);
      cyc(0, 1, DEV, 1, 0, 0, 0, 0);
      check("coni_b22", 36'(dout[13]), 36'd1);
      idle(0);
      cyc(0, 0, DEV, 0, 0, 1, 0, 36'd2);
      check("feint_clr", 36'(fe_int), 36'd0);
      // Collisions: KL set vs FE clear, FE set vs KL clear
      cyc(0, 1, DEV, 0, (36'd1 << 13) | (36'd1 << 12), 1, 0, 36'd3);
      check("coll_11", 36'(fe_int), 36'd1);
      idle(0);
      check("coll_10", fe_dout, 36'd3);

      // Long demand: single CONO effect; TO10DB set by FE mid-hold stays set
      cono(36'o000000000033);             // PIEN=1, PICH=3
      for (int i = 0; i < 10; i++)
         cyc(0, 1, DEV, 0, 36'd1 << 12, (i == 3), 0, 36'd1);
      check("long_pi", 36'(pi), 36'(7'b0010000));
      idle(0);

      // Mid-transfer reset
      cyc(0, 1, DEV, 2, 36'o5, 0, 1, 0);
      cyc(1, 1, DEV, 2, 36'o5, 0, 1, 0);
      check("crobar_xfer", 36'(xfer), 36'd0);
      idle(0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [35:0] d, fd;
         d  = {$urandom, $urandom} & 36'hF_FFFF_FFFF;
         fd = {$urandom, $urandom} & 36'hF_FFFF_FFFF;
         cyc(($urandom_range(0, 63) == 0),
             ($urandom_range(0, 2) != 0),
             ($urandom_range(0, 3) != 0) ? DEV : 7'($urandom),
             3'($urandom),
             d,
             ($urandom_range(0, 2) == 0),
             2'($urandom),
             fd);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
